// File: rtl/bfly_seq.sv
`default_nettype none
// ============================================================================
// Module   : bfly_seq
// Brief    : Radix-2 butterfly sequencer; reads (a,b) register pairs, writes
//            a+b / a-b back in place. BFLY_SCALE_EN enables 1/2 scaling.
// Revision : 1.0 - initial release
// ============================================================================
module bfly_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         start,
    input  logic [4:0]   base_a,
    input  logic [4:0]   base_b,
    input  logic [4:0]   npairs,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [4:0]   Raddr1,
    output logic [4:0]   Raddr2,
    input  logic [N-1:0] Rdata1,
    input  logic [N-1:0] Rdata2,
    output logic         w,
    output logic         w2,
    output logic [N-1:0] Wdata,
    output logic [N-1:0] Wdata2
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [4:0]   r_idx;
    logic [4:0]   r_npairs;
    logic         w_accept;
    logic         w_last;
    logic [N-1:0] w_sum;
    logic [N-1:0] w_diff;
    logic         w_ovf;

    assign w_accept = (r_state == S_IDLE) && start && (npairs != 5'd0);
    assign w_last   = ((r_idx + 5'd1) == r_npairs);

`ifdef BFLY_SCALE_EN
    logic [N:0] w_sum_x;
    logic [N:0] w_diff_x;

    // One guard bit keeps the full-precision result before halving.
    assign w_sum_x  = {Rdata1[N-1], Rdata1} + {Rdata2[N-1], Rdata2};
    assign w_diff_x = {Rdata1[N-1], Rdata1} - {Rdata2[N-1], Rdata2};
    assign w_sum    = w_sum_x[N:1];
    assign w_diff   = w_diff_x[N:1];
    assign w_ovf    = 1'b0;
`else
    assign w_sum  = Rdata1 + Rdata2;
    assign w_diff = Rdata1 - Rdata2;
    assign w_ovf  = ((Rdata1[N-1] == Rdata2[N-1]) && (w_sum[N-1]  != Rdata1[N-1])) ||
                    ((Rdata1[N-1] != Rdata2[N-1]) && (w_diff[N-1] != Rdata1[N-1]));
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes decode straight from state so reset drops them without a clock.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        w      = 1'b0;
        w2     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_READ;
                end else if (start) begin
                    w_next = S_DONE;
                end
            end
            S_READ: begin
                busy   = 1'b1;
                w_next = S_CALC;
            end
            S_CALC: begin
                busy   = 1'b1;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                busy   = 1'b1;
                w      = (Raddr1 != Raddr2);
                w2     = 1'b1;
                w_next = w_last ? S_DONE : S_READ;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_idx    <= 5'd0;
            r_npairs <= 5'd0;
            Raddr1   <= 5'd0;
            Raddr2   <= 5'd0;
            Wdata    <= '0;
            Wdata2   <= '0;
            ovf      <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                ovf <= 1'b0;
            end
            if (w_accept) begin
                r_npairs <= npairs;
                r_idx    <= 5'd0;
                Raddr1   <= base_a;
                Raddr2   <= base_b;
            end
            if (r_state == S_CALC) begin
                Wdata  <= w_sum;
                Wdata2 <= w_diff;
                if (w_ovf) begin
                    ovf <= 1'b1;
                end
            end
            // Addresses advance only between pairs so writes land where read.
            if (r_state == S_WRITE) begin
                r_idx <= r_idx + 5'd1;
                if (!w_last) begin
                    Raddr1 <= Raddr1 + 5'd1;
                    Raddr2 <= Raddr2 + 5'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bfly_seq.sv
`default_nettype none
// Testbench for bfly_seq: register-file model, scoreboard of expected write-backs
// and completions, randomized commands checked against an arithmetic model.
module tb_bfly_seq;

    localparam int N    = 8;
    localparam int MAXP = 2**(N-1) - 1;
    localparam int MINN = -(2**(N-1));

    logic         clk = 1'b0;
    logic         nReset;
    logic         start;
    logic [4:0]   base_a, base_b, npairs;
    logic         busy, done, ovf;
    logic [4:0]   Raddr1, Raddr2;
    logic [N-1:0] Rdata1, Rdata2;
    logic         w, w2;
    logic [N-1:0] Wdata, Wdata2;

    bfly_seq #(.N(N)) dut (
        .clk(clk), .nReset(nReset), .start(start),
        .base_a(base_a), .base_b(base_b), .npairs(npairs),
        .busy(busy), .done(done), .ovf(ovf),
        .Raddr1(Raddr1), .Raddr2(Raddr2),
        .Rdata1(Rdata1), .Rdata2(Rdata2),
        .w(w), .w2(w2), .Wdata(Wdata), .Wdata2(Wdata2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: synchronous read, register 0 reads 0 and ignores writes.
    logic [N-1:0] mem [32];
    logic [N-1:0] pre [32];
    logic [N-1:0] exp_mem [32];
    logic         load = 1'b0;

    always @(posedge clk) begin
        Rdata1 <= (Raddr1 == 5'd0) ? '0 : mem[Raddr1];
        Rdata2 <= (Raddr2 == 5'd0) ? '0 : mem[Raddr2];
        if (load) begin
            for (int i = 0; i < 32; i++) mem[i] <= pre[i];
        end else begin
            if (w  && Raddr1 != 5'd0) mem[Raddr1] <= Wdata;
            if (w2 && Raddr2 != 5'd0) mem[Raddr2] <= Wdata2;
        end
    end

    typedef struct {
        logic [4:0]   a1;
        logic [4:0]   a2;
        logic         we1;
        logic [N-1:0] d1;
        logic [N-1:0] d2;
    } wr_t;

    wr_t wq[$];
    bit  dq[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: process pairs in order on a plain array using integer arithmetic.
    task automatic model_cmd(input logic [4:0] ba, input logic [4:0] bb, input logic [4:0] np);
        bit ov = 1'b0;
        for (int i = 0; i < int'(np); i++) begin
            logic [4:0] x, y;
            int a, b, s, d, r1, r2;
            wr_t e;
            x = ba + 5'(i);
            y = bb + 5'(i);
            a = (x == 5'd0) ? 0 : int'($signed(exp_mem[x]));
            b = (y == 5'd0) ? 0 : int'($signed(exp_mem[y]));
            s = a + b;
            d = a - b;
`ifdef BFLY_SCALE_EN
            r1 = s >>> 1;
            r2 = d >>> 1;
`else
            r1 = s;
            r2 = d;
            if (s > MAXP || s < MINN || d > MAXP || d < MINN) ov = 1'b1;
`endif
            e.a1 = x; e.a2 = y; e.we1 = (x != y);
            e.d1 = r1[N-1:0]; e.d2 = r2[N-1:0];
            wq.push_back(e);
            if (x != y && x != 5'd0) exp_mem[x] = e.d1;
            if (y != 5'd0) exp_mem[y] = e.d2;
        end
        dq.push_back(ov);
    endtask

    wr_t mon_e;
    bit  mon_ov;
    always @(negedge clk) begin
        if (nReset) begin
            if (w || w2) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got w=%0b w2=%0b a1=%0d a2=%0d, required none", w, w2, Raddr1, Raddr2);
                end else begin
                    mon_e = wq.pop_front();
                    if ({Raddr1, Raddr2, w, w2, Wdata, Wdata2} !==
                        {mon_e.a1, mon_e.a2, mon_e.we1, 1'b1, mon_e.d1, mon_e.d2}) begin
                        errors++;
                        $display("FAIL writeback: got a1=%0d a2=%0d w=%0b w2=%0b d1=%0h d2=%0h, required a1=%0d a2=%0d w=%0b w2=1 d1=%0h d2=%0h",
                                 Raddr1, Raddr2, w, w2, Wdata, Wdata2,
                                 mon_e.a1, mon_e.a2, mon_e.we1, mon_e.d1, mon_e.d2);
                    end
                end
            end
            if (done) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got done=1, required 0");
                end else begin
                    mon_ov = dq.pop_front();
                    if (ovf !== mon_ov || busy !== 1'b0 || wq.size() != 0) begin
                        errors++;
                        $display("FAIL done_status: got ovf=%0b busy=%0b pending_writes=%0d, required ovf=%0b busy=0 pending_writes=0",
                                 ovf, busy, wq.size(), mon_ov);
                    end
                end
            end
        end
    end

    task automatic preload();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = pre[i];
        exp_mem[0] = '0;
    endtask

    task automatic clear_pre();
        for (int i = 0; i < 32; i++) pre[i] = '0;
    endtask

    task automatic run_cmd(input logic [4:0] ba, input logic [4:0] bb, input logic [4:0] np, input int hold);
        int c0;
        int bad;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        base_a = ba; base_b = bb; npairs = np; start = 1'b1;
        model_cmd(ba, bb, np);
        @(posedge clk);
        #1 c0 = cyc;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (t == 0) chk("busy_after_start", {31'd0, busy}, {31'd0, np != 5'd0});
            if (t + 1 < hold) begin
                base_a = 5'($urandom); base_b = 5'($urandom);
                npairs = 5'($urandom_range(1, 31));
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                chk("done_latency", cyc - c0, 3 * int'(np));
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done in 400 cycles, required done");
        end
        bad = -1;
        for (int i = 1; i < 32; i++) if (bad < 0 && mem[i] !== exp_mem[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL regfile: r%0d got %0h expected %0h", bad, mem[bad], exp_mem[bad]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset = 1'b0; start = 1'b0;
        base_a = '0; base_b = '0; npairs = '0;
        clear_pre();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, ovf, w, w2}, 5'b0);
        chk("reset_addr", {Raddr1, Raddr2}, 10'd0);
        chk("reset_data", {Wdata, Wdata2}, '0);
        nReset = 1'b1;
        preload();

        // Single pair
        clear_pre(); pre[1] = 8'd11; pre[2] = 8'd12; preload();
        run_cmd(5'd1, 5'd2, 5'd1, 1);
        chk("single_r1", mem[1], 8'd23);
        chk("single_r2", mem[2], 8'hFF);
        chk("single_ovf", ovf, 1'b0);

        // Four pairs
        clear_pre();
        for (int i = 1; i <= 4; i++) begin pre[i] = 8'(i); pre[i+4] = 8'd1; end
        preload();
        run_cmd(5'd1, 5'd5, 5'd4, 1);
        chk("four_r4", mem[4], 8'd5);
        chk("four_r8", mem[8], 8'd3);

        // npairs = 0
        run_cmd(5'd1, 5'd5, 5'd0, 1);

        // Overflow and its stickiness
        clear_pre(); pre[1] = 8'h7F; pre[2] = 8'h01; preload();
        run_cmd(5'd1, 5'd2, 5'd1, 1);
        repeat (3) @(negedge clk);
`ifdef BFLY_SCALE_EN
        chk("ovf_r1", mem[1], 8'h40);
        chk("ovf_r2", mem[2], 8'h3F);
        chk("ovf_sticky", ovf, 1'b0);
`else
        chk("ovf_r1", mem[1], 8'h80);
        chk("ovf_r2", mem[2], 8'h7E);
        chk("ovf_sticky", ovf, 1'b1);
`endif

        // Address wrap through register 0, then a collision pair
        clear_pre(); pre[31] = 8'd7; pre[1] = 8'd5; pre[3] = 8'd9; preload();
        run_cmd(5'd31, 5'd0, 5'd2, 1);
        run_cmd(5'd3, 5'd3, 5'd1, 1);
        chk("collide_r3", mem[3], 8'd0);

        // Start held high and inputs toggled while busy
        for (int i = 0; i < 32; i++) pre[i] = 8'($urandom);
        preload();
        run_cmd(5'd10, 5'd20, 5'd3, 4);

        // Asynchronous reset during WRITE
        clear_pre(); pre[1] = 8'd3; pre[2] = 8'd4; preload();
        @(negedge clk);
        base_a = 5'd1; base_b = 5'd2; npairs = 5'd2; start = 1'b1;
        model_cmd(5'd1, 5'd2, 5'd2);
        @(negedge clk) start = 1'b0;
        for (int t = 0; t < 20 && !w2; t++) @(negedge clk);
        chk("pre_reset_w2", w2, 1'b1);
        #2 nReset = 1'b0;
        #1;
        chk("async_reset_ctrl", {busy, done, w, w2}, 4'b0);
        chk("async_reset_addr", {Raddr1, Raddr2}, 10'd0);
        wq.delete(); dq.delete();
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", {busy, done, w, w2}, 4'b0);
        preload();
        run_cmd(5'd1, 5'd2, 5'd2, 1);

        // Randomized commands
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 32; i++) pre[i] = 8'($urandom);
            preload();
            run_cmd(5'($urandom), 5'($urandom), 5'($urandom_range(1, 8)), 1);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bfly_seq.md
Name: bfly_seq

Overview:
- Radix-2 butterfly sequencer sitting directly on the pMIPS 32 x n dual-port register file (regs).
- Drives the regs read ports, consumes Rdata1/Rdata2, computes sum = a+b and diff = a-b, and writes both results back in place through the two write ports.
- Processes npairs consecutive (a,b) register pairs per start command.

Parameters:
n, 8, data width of each register and of all data ports.

Ports:
clk  input  1  system clock; all state changes on rising edge
nReset  input  1  asynchronous, active-low reset
start  input  1  command strobe; sampled only in IDLE
base_a  input  5  register index of first "a" operand
base_b  input  5  register index of first "b" operand
npairs  input  5  number of butterflies to run; 0 = none
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last write-back
ovf  output  1  sticky overflow flag; cleared on accepted start
Raddr1  output  5  regs port-1 address, read and write
Raddr2  output  5  regs port-2 address, read and write
Rdata1  input  n  regs port-1 synchronous read data, 1-cycle latency
Rdata2  input  n  regs port-2 synchronous read data
w  output  1  regs port-1 write enable
w2  output  1  regs port-2 write enable
Wdata  output  n  sum result to port 1
Wdata2  output  n  diff result to port 2

Behaviour:
- Interface: one clock (clk). Reset nReset is asynchronous and active-low.
- regs writes land at the current Raddr1/Raddr2. The block therefore holds the addresses constant across READ, CALC and WRITE.
- Reset values: busy=0, done=0, ovf=0, w=0, w2=0, Raddr1=0, Raddr2=0, Wdata=0, Wdata2=0.
- FSM states: IDLE, READ, CALC, WRITE, DONE.
- IDLE: if start=1 and npairs!=0, latch base_a, base_b and npairs, clear idx and ovf, then go to READ.
- IDLE, start=1 and npairs=0: go to DONE; no regs access occurs.
- IDLE, start=0: stay in IDLE.
- READ: Raddr1 = base_a+idx and Raddr2 = base_b+idx, each mod 32 (5-bit wrap, 31+1 -> 0). Next state CALC.
- CALC: Rdata1/Rdata2 are valid.
  - Register Wdata = (a+b)[n-1:0] and Wdata2 = (a-b)[n-1:0], two's complement.
  - Set ovf if the signed sum or difference overflows n bits.
  - Next state WRITE.
- WRITE: assert w=1 and w2=1 for exactly one cycle; idx increments.
  - If idx+1 == npairs, go to DONE; otherwise go to READ.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Throughput and latency: 3 cycles per pair. The first write occurs 3 cycles after the start-accept edge; done follows 3*npairs+1 cycles after it.
- w and w2 are low in every state except WRITE. Wdata/Wdata2 hold their values outside CALC.
- Address collision (Raddr1 == Raddr2 during WRITE): w=0, w2=1, so only the diff is written. ovf is unaffected.
- Address 0: reads return 0. Writes are issued as normal and discarded by regs; no error is raised.
- start while busy: ignored, no restart and no latch. Input changes while busy are also ignored.
- nReset low mid-operation: all outputs return to reset values immediately, including w/w2 dropping without waiting for a clock edge. The FSM returns to IDLE and the partial block is abandoned.

Optional Feature:
BFLY_SCALE_EN:
- Defined: sum and diff are computed at n+1 bits and arithmetically shifted right by 1 before truncation to n bits (per-stage 1/2 scaling). ovf is then never set.
- Undefined: results wrap modulo 2^n and ovf operates as above.

Test Plan:
- Single pair, n=8. Preload r1=11 and r2=12; start with base_a=1, base_b=2, npairs=1 -> one w/w2 pulse; r1=23, r2=0xFF (-1); done pulses on cycle 4; ovf=0.
- Four pairs. r1..r4=1,2,3,4 and r5..r8=1,1,1,1; base_a=1, base_b=5, npairs=4 -> r1..r4=2,3,4,5 and r5..r8=0,1,2,3; 12 cycles of activity; exactly 4 write pulses.
- Overflow. r1=0x7F, r2=0x01 -> r1=0x80, r2=0x7E, ovf=1 and stays 1 until the next start. With BFLY_SCALE_EN: r1=0x40, r2=0x3F, ovf=0.
- Wrap and zero register. base_a=31, base_b=0, npairs=2 -> second pair uses addresses 0 and 1. Writes to %0 are discarded and Raddr reads of 0 return 0. A collision pair (base_a=base_b=3, r3=9) yields only w2 asserted and r3=0.
- Control corner cases. npairs=0 -> done on the next cycle with no w/w2 activity. A start asserted while busy is ignored.
- Reset mid-op. nReset driven low during WRITE -> w, w2 and busy fall asynchronously. After release the block idles, and a new start runs normally.
